// File: rtl/mem_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_stage_pkg: shared encodings for the MEM stage and its memory.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mem_stage_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [1:0] BR_EQ     = 2'b00;
  localparam logic [1:0] BR_NE     = 2'b01;
  localparam logic [1:0] BR_LTZ    = 2'b10;
  localparam logic [1:0] BR_ALWAYS = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // The reserved size code behaves as a word.
  function automatic logic isAligned(input logic [1:0] size, input logic [1:0] lowAddr);
    case (size)
      SIZE_BYTE: isAligned = 1'b1;
      SIZE_HALF: isAligned = ~lowAddr[0];
      default:   isAligned = (lowAddr == 2'b00);
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_memory_be.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | data_memory_be: word-organised RAM, byte-enabled sync write,         |
// | combinational read.                     Revision: 1.0                |
// +----------------------------------------------------------------------+
module data_memory_be #(
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                  Clk,
  input  logic                  WrEn,
  input  logic [DATA_W/8-1:0]   ByteEn,
  input  logic [IDX_W-1:0]      Addr,
  input  logic [DATA_W-1:0]     WrData,
  output logic [DATA_W-1:0]     RdData
);

  logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge Clk) begin
    for (int i = 0; i < DATA_W/8; i++) begin
      if (WrEn && ByteEn[i]) begin
        r_mem[Addr][i*8 +: 8] <= WrData[i*8 +: 8];
      end
    end
  end

  assign RdData = r_mem[Addr];

endmodule
`default_nettype wire

// File: rtl/mem_stage_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_stage_unit: MEM pipeline stage with branch resolve, multi-cycle  |
// | byte-enabled memory access and MEM/WB register. Revision: 1.0        |
// +----------------------------------------------------------------------+
module mem_stage_unit
  import mem_stage_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int MEM_LATENCY = 2,
  parameter int REG_ADDR_W  = 5
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  ValidIn,
  input  logic                  BranchIn,
  input  logic [1:0]            BranchTypeIn,
  input  logic                  MemReadIn,
  input  logic                  MemWriteIn,
  input  logic                  RegWriteIn,
  input  logic                  MemToRegIn,
  input  logic [1:0]            SizeIn,
  input  logic                  SignedIn,
  input  logic [ADDR_W-1:0]     BranchTargetAddressIn,
  input  logic [DATA_W-1:0]     ALUIn,
  input  logic                  ZeroIn,
  input  logic [DATA_W-1:0]     MemoryWriteDataIn,
  input  logic [REG_ADDR_W-1:0] DestinationRegIn,
  output logic                  PCSrcOut,
  output logic [ADDR_W-1:0]     BranchTargetOut,
  output logic                  StallOut,
  output logic                  ValidOut,
  output logic                  RegWriteOut,
  output logic                  MemToRegOut,
  output logic [DATA_W-1:0]     ALUOut,
  output logic [DATA_W-1:0]     DataMemOut,
  output logic [REG_ADDR_W-1:0] DestinationRegOut,
  output logic                  MisalignOut
);

  localparam int c_idxW   = $clog2(DEPTH_WORDS);
  localparam int c_bytes  = DATA_W / 8;
  localparam int c_cntW   = $clog2(MEM_LATENCY) + 1;
  localparam logic [c_cntW-1:0] c_lastCnt = c_cntW'(MEM_LATENCY - 1);

  state_t              r_state, w_nextState;
  logic [c_cntW-1:0]   r_cnt, w_nextCnt;
  logic                w_stallRaw, w_complete, w_bubble;
  logic                w_cond, w_access, w_aligned, w_memOp, w_misalign, w_isLoad, w_wrEn;
  logic [1:0]          w_lane;
  logic [c_bytes-1:0]  w_byteEn;
  logic [DATA_W-1:0]   w_wrData, w_rdWord, w_shifted, w_loadData;

  assign w_lane     = ALUIn[1:0];
  assign w_aligned  = isAligned(SizeIn, w_lane);
  assign w_access   = ValidIn & (MemReadIn | MemWriteIn);
  assign w_memOp    = w_access & w_aligned;
  assign w_misalign = w_access & ~w_aligned;
  assign w_isLoad   = MemReadIn & ~MemWriteIn;

  always_comb begin
    case (BranchTypeIn)
      BR_EQ:   w_cond = ZeroIn;
      BR_NE:   w_cond = ~ZeroIn;
      BR_LTZ:  w_cond = ALUIn[DATA_W-1];
      default: w_cond = 1'b1;
    endcase
  end

  assign PCSrcOut        = ValidIn & BranchIn & w_cond;
  assign BranchTargetOut = BranchTargetAddressIn;
  // Stall is masked during reset so upstream is released at once.
  assign StallOut        = Rst_n & w_stallRaw;

  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_stallRaw  = 1'b0;
    w_complete  = 1'b0;
    w_bubble    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_memOp) begin
          if (MEM_LATENCY == 1) begin
            w_complete = 1'b1;
          end else begin
            w_stallRaw  = 1'b1;
            w_nextState = ST_BUSY;
            w_nextCnt   = c_cntW'(1);
            w_bubble    = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        w_stallRaw = (r_cnt != c_lastCnt);
        if (r_cnt < c_lastCnt) begin
          w_nextCnt = r_cnt + c_cntW'(1);
          w_bubble  = 1'b1;
        end else begin
          w_complete  = w_memOp;
          w_nextState = ST_IDLE;
          w_nextCnt   = '0;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
        w_nextCnt   = '0;
      end
    endcase
  end

  always_comb begin
    case (SizeIn)
      SIZE_BYTE: w_byteEn = c_bytes'(1) << w_lane;
      SIZE_HALF: w_byteEn = c_bytes'(3) << w_lane;
      default:   w_byteEn = '1;
    endcase
  end

  assign w_wrData = MemoryWriteDataIn << {w_lane, 3'b000};
  assign w_wrEn   = Rst_n & w_complete & MemWriteIn;

  data_memory_be #(
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_mem (
    .Clk    (Clk),
    .WrEn   (w_wrEn),
    .ByteEn (w_byteEn),
    .Addr   (ALUIn[2 +: c_idxW]),
    .WrData (w_wrData),
    .RdData (w_rdWord)
  );

  assign w_shifted = w_rdWord >> {w_lane, 3'b000};

  always_comb begin
    case (SizeIn)
      SIZE_BYTE: w_loadData = {{(DATA_W-8){SignedIn & w_shifted[7]}}, w_shifted[7:0]};
      SIZE_HALF: w_loadData = {{(DATA_W-16){SignedIn & w_shifted[15]}}, w_shifted[15:0]};
      default:   w_loadData = w_rdWord;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state           <= ST_IDLE;
      r_cnt             <= '0;
      ValidOut          <= 1'b0;
      RegWriteOut       <= 1'b0;
      MemToRegOut       <= 1'b0;
      ALUOut            <= '0;
      DataMemOut        <= '0;
      DestinationRegOut <= '0;
      MisalignOut       <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      if (w_bubble) begin
        ValidOut          <= 1'b0;
        RegWriteOut       <= 1'b0;
        MemToRegOut       <= 1'b0;
        ALUOut            <= '0;
        DataMemOut        <= '0;
        DestinationRegOut <= '0;
        MisalignOut       <= 1'b0;
      end else begin
        ValidOut          <= ValidIn;
        RegWriteOut       <= RegWriteIn & ~w_misalign;
        MemToRegOut       <= MemToRegIn;
        ALUOut            <= ALUIn;
        DataMemOut        <= (w_complete & w_isLoad) ? w_loadData : '0;
        DestinationRegOut <= DestinationRegIn;
        MisalignOut       <= w_misalign;
      end
    end
  end

endmodule
`default_nettype wire
